// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RISC-V control sequencer.
// Walks each instruction through FETCH / DECODE / EXEC / MEM / WB, drives the
// datapath strobes and memory handshake, and parks in TRAP on an illegal
// instruction until reset.
module riscv_mc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [3:0]  alu_op,
  output logic        alu_src_b,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  state_e state_q, state_d;

  // Instruction field extraction and classification
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic       is_jump, is_legal, br_taken;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign rd        = instr[11:7];
  assign is_r      = (opcode == OpR);
  assign is_imm    = (opcode == OpImm);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign is_lui    = (opcode == OpLui);
  assign is_jump   = is_jal | is_jalr;

  assign is_legal = is_r | is_imm | is_lui | is_jump
                  | ((is_load | is_store) & (funct3 == 3'b010))
                  | (is_branch & (funct3[2:1] == 2'b00));

  assign br_taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);

  // Bits of the IR this block never looks at
  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15]};

  // ALU control decoded straight from the opcode
  logic [3:0] alu_op_dec;
  logic       alu_src_b_dec;

  always_comb begin
    alu_op_dec    = 4'b0000;
    alu_src_b_dec = 1'b1;
    case (opcode)
      OpR: begin
        alu_op_dec    = {instr[30], funct3};
        alu_src_b_dec = 1'b0;
      end
      // Only the shift-right pair uses funct7[5] to pick SRA vs SRL
      OpImm:    alu_op_dec = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
      OpBranch: begin
        alu_op_dec    = 4'b1000;
        alu_src_b_dec = 1'b0;
      end
      OpLui:    alu_op_dec = 4'b1111;
      default:  alu_op_dec = 4'b0000;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: state_d = is_legal ? StExec : StTrap;
      StExec: begin
        if (is_branch) begin
          state_d = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem:    if (mem_ready) state_d = is_store ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  // Output decode; rst_n gating makes reset silence the bus without a clock edge
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    alu_op    = 4'b0000;
    alu_src_b = 1'b0;
    illegal   = 1'b0;
    if (rst_n) begin
      if (state_q inside {StDecode, StExec, StMem, StWb}) begin
        alu_op    = alu_op_dec;
        alu_src_b = alu_src_b_dec;
      end
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        StExec: begin
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_src = br_taken ? 2'b01 : 2'b00;
          end
        end
        StMem: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = is_store;
          pc_we   = mem_ready & is_store;
        end
        StWb: begin
          rf_we  = (rd != 5'd0);
          pc_we  = 1'b1;
          pc_src = is_jump ? 2'b10 : 2'b00;
          wb_sel = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
        end
        StTrap:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Randomized self-checking bench for riscv_mc_sequencer.
// A transaction-level model predicts, per instruction, the visited state
// sequence, latency, and strobe totals from the instruction class.
module tb_riscv_mc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src_b, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  riscv_mc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .illegal   (illegal),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction classes: 0 = ALU/jump/LUI (writes back), 1 = branch, 2 = store, 3 = load
  function automatic int cls_of(input logic [31:0] i);
    case (i[6:0])
      7'b1100011: return 1;
      7'b0100011: return 2;
      7'b0000011: return 3;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu_op(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return {i[30], i[14:12]};
      7'b0010011: return (i[14:12] == 3'b101) ? {i[30], i[14:12]} : {1'b0, i[14:12]};
      7'b1100011: return 4'b1000;
      7'b0110111: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic logic exp_src_b(input logic [31:0] i);
    return !(i[6:0] == 7'b0110011 || i[6:0] == 7'b1100011);
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [6:0]  ops [8];
    logic [31:0] i;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    i = $urandom;
    i[6:0] = ops[$urandom_range(0, 7)];
    if (i[6:0] == 7'b0000011 || i[6:0] == 7'b0100011) i[14:12] = 3'b010;
    if (i[6:0] == 7'b1100011) i[14:12] = 3'($urandom_range(0, 1));
    if (i[6:0] == 7'b1100111) i[14:12] = 3'b000;
    if (i[6:0] == 7'b0110011) i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) == 0) i[11:7] = 5'd0;
    return i;
  endfunction

  function automatic logic [31:0] gen_illegal();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 2))
      0: begin
        i[6:0] = 7'b0000011;
        if ($urandom_range(0, 1) == 1) i[6:0] = 7'b0100011;
        if (i[14:12] == 3'b010) i[14:12] = 3'b011;
      end
      1: begin
        i[6:0] = 7'b1100011;
        i[14:12] = 3'($urandom_range(2, 7));
      end
      default: begin
        while (i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111})
          i[6:0] = 7'($urandom);
      end
    endcase
    return i;
  endfunction

  // One legal instruction: fw fetch wait cycles, mw memory wait cycles, z = zero flag
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
    int   cls, lat, mem_start, mwait;
    int   seq[$];
    logic plan[$];
    int   n_ir, ir_cyc, n_pc, pc_cyc, n_rf, n_mreq, n_msel, n_mwe;
    logic [1:0] pc_src_s, wb_sel_s, exp_pc, exp_wb;
    logic has_mem, has_wb, jump, taken;
    cls     = cls_of(ins);
    has_mem = (cls >= 2);
    has_wb  = (cls == 0) || (cls == 3);
    jump    = (ins[6:0] == 7'b1101111) || (ins[6:0] == 7'b1100111);
    taken   = ((ins[14:12] == 3'b000) && z) || ((ins[14:12] == 3'b001) && !z);
    mwait   = has_mem ? mw : 0;
    lat     = ((cls == 1) ? 3 : (cls == 3) ? 5 : 4) + fw + mwait;
    repeat (fw + 1) seq.push_back(0);
    seq.push_back(1);
    seq.push_back(2);
    if (has_mem) repeat (mwait + 1) seq.push_back(3);
    if (has_wb) seq.push_back(4);
    mem_start = fw + 3;
    for (int c = 0; c < lat; c++) begin
      if (c < fw) plan.push_back(1'b0);
      else if (c == fw) plan.push_back(1'b1);
      else if (has_mem && c >= mem_start && c < mem_start + mwait) plan.push_back(1'b0);
      else if (has_mem && c == mem_start + mwait) plan.push_back(1'b1);
      else plan.push_back(1'($urandom_range(0, 1)));
    end
    exp_pc = (cls == 1) ? (taken ? 2'b01 : 2'b00) : (jump ? 2'b10 : 2'b00);
    exp_wb = (cls == 3) ? 2'b01 : (jump ? 2'b10 : 2'b00);
    n_ir = 0; ir_cyc = -1; n_pc = 0; pc_cyc = -1; n_rf = 0;
    n_mreq = 0; n_msel = 0; n_mwe = 0; pc_src_s = 2'b11; wb_sel_s = 2'b11;
    instr = ins;
    zero  = z;
    for (int c = 0; c < lat; c++) begin
      mem_ready = plan[c];
      @(negedge clk);
      check_eq("state", {29'd0, state}, seq[c]);
      check_eq("alu_op", {28'd0, alu_op}, (c <= fw) ? 32'd0 : {28'd0, exp_alu_op(ins)});
      check_eq("alu_src_b", {31'd0, alu_src_b}, (c <= fw) ? 32'd0 : {31'd0, exp_src_b(ins)});
      if (ir_we) begin n_ir++; ir_cyc = c; end
      if (pc_we) begin n_pc++; pc_cyc = c; pc_src_s = pc_src; end
      if (rf_we) n_rf++;
      if (mem_req) n_mreq++;
      if (mem_req && mem_sel) n_msel++;
      if (mem_req && mem_we) n_mwe++;
      if (c == lat - 1) wb_sel_s = wb_sel;
      @(posedge clk);
      #1;
    end
    check_eq("ir_we_count", n_ir, 1);
    check_eq("ir_we_cycle", ir_cyc, fw);
    check_eq("pc_we_count", n_pc, 1);
    check_eq("pc_we_cycle", pc_cyc, lat - 1);
    check_eq("pc_src", {30'd0, pc_src_s}, {30'd0, exp_pc});
    check_eq("rf_we_count", n_rf, (has_wb && ins[11:7] != 5'd0) ? 1 : 0);
    if (has_wb) check_eq("wb_sel", {30'd0, wb_sel_s}, {30'd0, exp_wb});
    check_eq("mem_req_cycles", n_mreq, fw + 1 + (has_mem ? mwait + 1 : 0));
    check_eq("mem_sel_cycles", n_msel, has_mem ? mwait + 1 : 0);
    check_eq("mem_we_cycles", n_mwe, (cls == 2) ? mwait + 1 : 0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_mem_req", {31'd0, mem_req}, 0);
    check_eq("rst_async_state", {29'd0, state}, 0);
    check_eq("rst_async_illegal", {31'd0, illegal}, 0);
    @(posedge clk);
    #1;
    check_eq("rst_outputs", {mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src_b,
                             illegal, pc_src, wb_sel, alu_op, state}, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_mem_req", {31'd0, mem_req}, 1);
  endtask

  // Illegal instruction: fetch, decode, then parked in TRAP until reset
  task automatic run_illegal(input logic [31:0] ins, input int fw);
    instr = ins;
    zero  = 1'($urandom);
    for (int c = 0; c <= fw + 1; c++) begin
      mem_ready = (c == fw);
      @(negedge clk);
      check_eq("ill_pre_state", {29'd0, state}, (c <= fw) ? 0 : 1);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      check_eq("trap_state", {29'd0, state}, 7);
      check_eq("trap_illegal", {31'd0, illegal}, 1);
      check_eq("trap_strobes", {28'd0, mem_req, ir_we, pc_we, rf_we}, 0);
      @(posedge clk);
      #1;
    end
    do_reset();
    check_eq("post_trap_state", {29'd0, state}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    instr     = 32'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #12;
    check_eq("reset_outputs", {mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src_b,
                               illegal, pc_src, wb_sel, alu_op, state}, 0);
    mem_ready = 1'b1;
    #1;
    check_eq("reset_ignores_ready", {31'd0, mem_req}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("first_fetch_req", {31'd0, mem_req}, 1);

    run_instr(32'h003100B3, 0, 0, 1'b0);  // ADD
    run_instr(32'h403100B3, 0, 0, 1'b0);  // SUB
    run_instr(32'h00812283, 0, 3, 1'b0);  // LW, 3 wait cycles
    run_instr(32'h00000063, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h00000063, 0, 0, 1'b0);  // BEQ not taken
    run_instr(32'h00112423, 1, 2, 1'b0);  // SW with waits

    for (int k = 0; k < 150; k++)
      run_instr(gen_legal(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));

    run_illegal(32'hFFFFFFFF, 0);
    for (int k = 0; k < 6; k++) run_illegal(gen_illegal(), $urandom_range(0, 2));

    // Reset during a MEM wait must drop mem_req without a clock edge
    instr     = 32'h00812283;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    check_eq("mem_wait_state", {29'd0, state}, 3);
    check_eq("mem_wait_req", {31'd0, mem_req}, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mem_rst_req", {31'd0, mem_req}, 0);
    check_eq("mem_rst_state", {29'd0, state}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("mem_rst_release_state", {29'd0, state}, 0);
    check_eq("mem_rst_release_sel", {31'd0, mem_sel}, 0);
    run_instr(32'h003100B3, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mc_sequencer.md
RISCV_MC_SEQUENCER -- requirements
Module: riscv_mc_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 instr  input  32  current IR contents; stable from DECODE until the next ir_we.
REQ-004 zero  input  1  ALU zero flag, valid in EXEC.
REQ-005 mem_ready  input  1  memory completes the current request in this cycle.
REQ-006 mem_req  output  1  memory request; held until mem_ready.
REQ-007 mem_we  output  1  1 = store, 0 = read; valid only with mem_req.
REQ-008 mem_sel  output  1  address select: 0 = PC (fetch), 1 = ALU result (data).
REQ-009 ir_we  output  1  IR load strobe.
REQ-010 pc_we  output  1  PC update strobe.
REQ-011 pc_src  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = ALU result (JAL/JALR).
REQ-012 rf_we  output  1  register-file write strobe.
REQ-013 wb_sel  output  2  write-back source: 00 = ALU, 01 = memory data, 10 = PC+4.
REQ-014 alu_op  output  4  ALU operation code.
REQ-015 alu_src_b  output  1  ALU B operand: 0 = rs2, 1 = immediate.
REQ-016 illegal  output  1  sticky illegal-instruction flag.
REQ-017 state  output  3  current state: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.

Function
REQ-018 Supported opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
- LOAD and STORE accept funct3 = 010 only.
- BRANCH accepts funct3 000 (BEQ) and 001 (BNE) only.
- Any other opcode or funct3 is illegal.
REQ-019 FETCH: assert mem_req=1, mem_sel=0, mem_we=0 every cycle.
- When mem_ready=1: ir_we=1 for that cycle; next state DECODE.
- Otherwise remain in FETCH.
REQ-020 DECODE: one cycle with no strobes asserted. Next state is TRAP if the instruction is illegal, otherwise EXEC.
REQ-021 alu_op is combinational from instr in DECODE, EXEC, MEM and WB:
- R: {funct7[5], funct3}.
- OP-IMM: {funct3==101 ? funct7[5] : 0, funct3}.
- LOAD, STORE, JAL, JALR: 0000.
- BRANCH: 1000.
- LUI: 1111.
- alu_src_b = 0 for R and BRANCH, 1 for all other opcodes.
REQ-022 EXEC: one cycle.
- R, OP-IMM, LUI, JAL, JALR: next state WB.
- LOAD, STORE: next state MEM.
- BRANCH: pc_we=1; pc_src=01 if taken, else 00; next state FETCH.
- Branch taken = (funct3==000 & zero) | (funct3==001 & ~zero).
REQ-023 MEM: mem_req=1, mem_sel=1, mem_we=1 for STORE (0 for LOAD), held until mem_ready.
- On mem_ready, STORE: pc_we=1, pc_src=00; next state FETCH.
- On mem_ready, LOAD: next state WB.
REQ-024 WB: one cycle.
- rf_we=1 only if instr[11:7] != 0.
- pc_we=1; pc_src=10 for JAL/JALR, else 00.
- wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
- Next state FETCH.
REQ-025 TRAP: illegal=1; all strobes (mem_req, ir_we, pc_we, rf_we) stay 0. TRAP is left only by reset.
REQ-026 Latency with zero wait states:
- R, OP-IMM, LUI, JAL, JALR: 4 cycles.
- BRANCH: 3 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.
- Each mem_ready wait cycle adds one cycle.
REQ-027 mem_ready outside FETCH and MEM is ignored.
REQ-028 Strobes (ir_we, pc_we, rf_we) are single-cycle pulses. Exactly one pc_we pulse per retired instruction.
REQ-029 All outputs are decoded from registered state and instr. No combinational path from mem_ready to mem_req.

Reset
REQ-030 While rst_n=0:
- state = FETCH.
- illegal = 0.
- mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src_b = 0.
- pc_src = 00, wb_sel = 00, alu_op = 0000.
REQ-031 Reset asserted mid-transaction (FETCH or MEM) drops mem_req immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, mem_req rises in the first cycle; the first fetch begins.

Verification
REQ-033 ADD 0x003100B3, mem_ready=1 in FETCH:
- State sequence 0,1,2,4,0.
- alu_op=0000, alu_src_b=0.
- In WB: rf_we=1, wb_sel=00, pc_we=1, pc_src=00.
REQ-034 SUB 0x403100B3: alu_op=1000 during EXEC; otherwise identical to REQ-033.
REQ-035 LW 0x00812283, with mem_ready held low for 3 cycles in MEM:
- mem_req=1, mem_sel=1, mem_we=0 for 4 MEM cycles.
- Then WB: rf_we=1, wb_sel=01.
- Total 8 cycles.
REQ-036 BEQ 0x00000063:
- With zero=1: EXEC gives pc_we=1, pc_src=01, rf_we=0; returns to FETCH after 3 cycles.
- With zero=0: pc_src=00.
REQ-037 Illegal instruction 0xFFFFFFFF:
- DECODE goes to TRAP (state=7); illegal=1.
- No further mem_req, despite mem_ready toggling.
- rst_n low clears illegal and returns state to 0.
REQ-038 Reset asserted during a MEM wait: mem_req=0 in the same cycle; after release, state=0 and mem_sel=0.
